arbitro_convertidor: RTL and testbench

ARBITRO_CONVERTIDOR -- requirements
Module: arbitro_convertidor

---
 rtl/arbitro_convertidor_if.sv | 27 ++
 rtl/arbitro_convertidor.sv | 169 ++++++++++++++++
 tb/tb_arbitro_convertidor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_convertidor_if.sv
// Handshake bundle for arbitro_convertidor: two-channel request side,
// the shared x5/2 converter link and the result/status side.
interface arbitro_convertidor_if;
   logic [1:0]  req_valid;
   logic [15:0] req_dato;
   logic [1:0]  req_ready;
   logic [7:0]  conv_in;
   logic [9:0]  conv_out;
   logic        out_valid;
   logic [9:0]  out_dato;
   logic        out_id;
   logic        out_ready;
   logic        busy;
   logic [7:0]  conv_count;

   // Block side: takes requests and converter result, produces grants and results.
   modport slave (
      input  req_valid, req_dato, conv_out, out_ready,
      output req_ready, conv_in, out_valid, out_dato, out_id, busy, conv_count
   );

   // Environment side: requesters, converter and result consumer.
   modport master (
      output req_valid, req_dato, conv_out, out_ready,
      input  req_ready, conv_in, out_valid, out_dato, out_id, busy, conv_count
   );
endinterface

// File: rtl/arbitro_convertidor.sv
// Two-channel round-robin arbiter in front of a shared combinational x5/2
// converter. One operand is in flight at a time: it is registered onto
// conv_in, left to settle for SETTLE_CYCLES clocks, then the converter
// output is captured and offered on the result handshake.
// SETTLE_CYCLES legal range is 1..15.
module arbitro_convertidor #(
   parameter int SETTLE_CYCLES = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   arbitro_convertidor_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Terminal value of the settle counter.
   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

   // Round-robin grant: on a tie the channel that did not win last time wins.
   function automatic logic [1:0] grant_of(input logic [1:0] valid, input logic last);
      logic [1:0] g;
      case (valid)
         2'b00:   g = 2'b00;
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = last ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [3:0] cnt_r;
   logic       last_grant_r;
   logic [7:0] conv_in_r;
   logic       out_valid_r;
   logic [9:0] out_dato_r;
   logic       out_id_r;
   logic [7:0] conv_count_r;
   logic       busy_r;

   logic [1:0] req_ready_s;
   logic       accept_s;
   logic       grant_id_s;
   logic [7:0] operand_s;
   logic       settle_end_s;
   logic       consume_s;

   // Grant only while idle; all other states refuse every channel.
   always_comb begin
      req_ready_s = 2'b00;
      if (state_r == ST_IDLE) begin
         req_ready_s = grant_of(bus.req_valid, last_grant_r);
      end else begin
         req_ready_s = 2'b00;
      end
   end

   assign accept_s     = |(bus.req_valid & req_ready_s);
   assign grant_id_s   = req_ready_s[1];
   assign settle_end_s = (state_r == ST_SETTLE) && (cnt_r == LAST_CNT);
   assign consume_s    = (state_r == ST_DONE) && out_valid_r && bus.out_ready;

   // Select the operand byte of the granted channel.
   always_comb begin
      operand_s = 8'd0;
      if (grant_id_s) begin
         operand_s = bus.req_dato[15:8];
      end else begin
         operand_s = bus.req_dato[7:0];
      end
   end

   // Next-state decode; an unreachable encoding falls back to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_SETTLE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (settle_end_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_DONE: begin
            if (consume_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and busy flag, kept in step with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
      end
   end

   // Operand capture, settle timing, result capture and completion count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r        <= 4'd0;
         last_grant_r <= 1'b1;
         conv_in_r    <= 8'd0;
         out_valid_r  <= 1'b0;
         out_dato_r   <= 10'd0;
         out_id_r     <= 1'b0;
         conv_count_r <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  conv_in_r    <= operand_s;
                  out_id_r     <= grant_id_s;
                  last_grant_r <= grant_id_s;
                  cnt_r        <= 4'd0;
               end
            end
            ST_SETTLE: begin
               if (settle_end_s) begin
                  out_dato_r  <= bus.conv_out;
                  out_valid_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            ST_DONE: begin
               if (consume_s) begin
                  out_valid_r <= 1'b0;
                  if (conv_count_r != 8'd255) begin
                     conv_count_r <= conv_count_r + 8'd1;
                  end
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               cnt_r       <= 4'd0;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.conv_in    = conv_in_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_dato   = out_dato_r;
   assign bus.out_id     = out_id_r;
   assign bus.busy       = busy_r;
   assign bus.conv_count = conv_count_r;

endmodule

// File: tb/tb_arbitro_convertidor.sv
// Directed bench for arbitro_convertidor: one instance with SETTLE_CYCLES=1
// and one with SETTLE_CYCLES=4, each driving a behavioural x5/2 converter.
module tb_arbitro_convertidor;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_total = 0;
   int   n_bad = 0;
   logic both_ready_seen = 1'b0;

   arbitro_convertidor_if ia ();
   arbitro_convertidor_if ib ();

   arbitro_convertidor #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   arbitro_convertidor #(.SETTLE_CYCLES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

   always #5 clk = ~clk;

   // Shared converter stand-in: floor(x*5/2).
   function automatic logic [9:0] conv_model(input logic [7:0] x);
      logic [10:0] p;
      p = {3'b000, x} * 11'd5;
      return p[10:1];
   endfunction

   assign ia.conv_out = conv_model(ia.conv_in);
   assign ib.conv_out = conv_model(ib.conv_in);

   // Watch for a double grant on either instance.
   always @(negedge clk) begin
      if (ia.req_ready == 2'b11 || ib.req_ready == 2'b11) both_ready_seen <= 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_out_a(output int lat);
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         lat++;
         if (ia.out_valid) break;
      end
   endtask

   task automatic wait_out_b(output int lat);
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         lat++;
         if (ib.out_valid) break;
      end
   endtask

   // One complete transfer on instance A with consumer always ready.
   task automatic run_a(input string tag, input logic ch, input logic [7:0] op,
                        input logic [9:0] exp, input logic [7:0] exp_cnt);
      int lat;
      ia.out_ready = 1'b1;
      ia.req_valid = ch ? 2'b10 : 2'b01;
      ia.req_dato  = ch ? {op, 8'h00} : {8'h00, op};
      #1;
      check_val({tag, "_ready"}, 32'(ia.req_ready), ch ? 32'd2 : 32'd1);
      tick();
      ia.req_valid = 2'b00;
      check_val({tag, "_busy"}, 32'(ia.busy), 32'd1);
      check_val({tag, "_conv_in"}, 32'(ia.conv_in), 32'(op));
      wait_out_a(lat);
      check_val({tag, "_lat"}, 32'(lat), 32'd1);
      check_val({tag, "_dato"}, 32'(ia.out_dato), 32'(exp));
      check_val({tag, "_id"}, 32'(ia.out_id), 32'(ch));
      tick();
      check_val({tag, "_vld_drop"}, 32'(ia.out_valid), 32'd0);
      check_val({tag, "_idle"}, 32'(ia.busy), 32'd0);
      check_val({tag, "_count"}, 32'(ia.conv_count), 32'(exp_cnt));
   endtask

   initial begin
      int lat;
      int got;
      int n;
      logic [9:0] res_d [2];
      logic       res_id [2];
      logic       seen;

      ia.req_valid = 2'b00; ia.req_dato = 16'd0; ia.out_ready = 1'b0;
      ib.req_valid = 2'b00; ib.req_dato = 16'd0; ib.out_ready = 1'b0;

      // Reset values while rst_n is low.
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_valid", 32'(ia.out_valid), 32'd0);
      check_val("rst_dato", 32'(ia.out_dato), 32'd0);
      check_val("rst_id", 32'(ia.out_id), 32'd0);
      check_val("rst_conv_in", 32'(ia.conv_in), 32'd0);
      check_val("rst_count", 32'(ia.conv_count), 32'd0);
      check_val("rst_busy", 32'(ia.busy), 32'd0);
      check_val("rst_ready", 32'(ia.req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic transfer and floor rounding.
      run_a("ch0_10", 1'b0, 8'd10, 10'd25, 8'd1);
      run_a("op0", 1'b1, 8'd0, 10'd0, 8'd2);
      run_a("op1", 1'b0, 8'd1, 10'd2, 8'd3);
      run_a("op3", 1'b1, 8'd3, 10'd7, 8'd4);

      // Tie after reset: ch0 first, then ch1.
      pulse_reset();
      ia.out_ready = 1'b1;
      ia.req_dato  = {8'd255, 8'd200};
      ia.req_valid = 2'b11;
      #1;
      check_val("tie_first_ready", 32'(ia.req_ready), 32'd1);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ia.out_valid) begin
            res_d[got]  = ia.out_dato;
            res_id[got] = ia.out_id;
            got++;
            if (got == 2) begin
               ia.req_valid = 2'b00;
               break;
            end
         end
      end
      check_val("tie_results", 32'(got), 32'd2);
      check_val("tie_r0_dato", 32'(res_d[0]), 32'd500);
      check_val("tie_r0_id", 32'(res_id[0]), 32'd0);
      check_val("tie_r1_dato", 32'(res_d[1]), 32'd637);
      check_val("tie_r1_id", 32'(res_id[1]), 32'd1);
      tick();
      tick();
      check_val("tie_idle", 32'(ia.busy), 32'd0);
      check_val("tie_count", 32'(ia.conv_count), 32'd2);

      // Back-pressure in DONE with both channels requesting.
      ia.out_ready = 1'b0;
      ia.req_dato  = {8'd0, 8'd100};
      ia.req_valid = 2'b01;
      tick();
      ia.req_valid = 2'b11;
      wait_out_a(lat);
      check_val("bp_dato0", 32'(ia.out_dato), 32'd250);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_val("bp_valid", 32'(ia.out_valid), 32'd1);
         check_val("bp_dato", 32'(ia.out_dato), 32'd250);
         check_val("bp_id", 32'(ia.out_id), 32'd0);
         check_val("bp_ready", 32'(ia.req_ready), 32'd0);
         check_val("bp_busy", 32'(ia.busy), 32'd1);
      end
      ia.out_ready = 1'b1;
      tick();
      check_val("bp_vld_drop", 32'(ia.out_valid), 32'd0);
      check_val("bp_idle", 32'(ia.busy), 32'd0);
      check_val("bp_next_grant", 32'(ia.req_ready), 32'd2);
      check_val("bp_count", 32'(ia.conv_count), 32'd3);
      ia.req_valid = 2'b00;
      tick();

      // SETTLE_CYCLES=4: latency, then reset mid-settle.
      ib.out_ready = 1'b1;
      ib.req_dato  = {8'd0, 8'd50};
      ib.req_valid = 2'b01;
      #1;
      check_val("b_ready", 32'(ib.req_ready), 32'd1);
      tick();
      ib.req_valid = 2'b00;
      wait_out_b(lat);
      check_val("b_lat", 32'(lat), 32'd4);
      check_val("b_dato", 32'(ib.out_dato), 32'd125);
      tick();
      check_val("b_count", 32'(ib.conv_count), 32'd1);
      ib.req_dato  = {8'd0, 8'd60};
      ib.req_valid = 2'b01;
      tick();
      ib.req_valid = 2'b00;
      tick();
      check_val("b_mid_busy", 32'(ib.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("b_abort_valid", 32'(ib.out_valid), 32'd0);
      check_val("b_abort_busy", 32'(ib.busy), 32'd0);
      check_val("b_abort_conv_in", 32'(ib.conv_in), 32'd0);
      check_val("b_abort_count", 32'(ib.conv_count), 32'd0);
      check_val("b_abort_dato", 32'(ib.out_dato), 32'd0);
      check_val("b_abort_id", 32'(ib.out_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ib.out_valid) seen = 1'b1;
      end
      check_val("b_no_result", 32'(seen), 32'd0);
      ib.req_dato  = {8'd90, 8'd40};
      ib.req_valid = 2'b11;
      #1;
      check_val("b_tie_ready", 32'(ib.req_ready), 32'd1);
      tick();
      ib.req_valid = 2'b00;
      wait_out_b(lat);
      check_val("b_tie_lat", 32'(lat), 32'd4);
      check_val("b_tie_dato", 32'(ib.out_dato), 32'd100);
      check_val("b_tie_id", 32'(ib.out_id), 32'd0);
      tick();

      // 300 back-to-back transfers saturate the counter.
      ia.out_ready = 1'b1;
      ia.req_dato  = {8'd0, 8'd7};
      ia.req_valid = 2'b01;
      n = 0;
      for (int c = 0; c < 1200; c++) begin
         tick();
         if (ia.out_valid) n++;
         if (n == 300) begin
            ia.req_valid = 2'b00;
            break;
         end
      end
      tick();
      tick();
      check_val("sat_results", 32'(n), 32'd300);
      check_val("sat_count", 32'(ia.conv_count), 32'd255);
      check_val("sat_dato", 32'(ia.out_dato), 32'd17);
      check_val("sat_idle", 32'(ia.busy), 32'd0);

      check_val("never_both_ready", 32'(both_ready_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Hard stop if the sequence above ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
